// File: rtl/prbs_gen_chk.sv
// PRBS pattern generator (valid/ready, DW bits per word) and self-synchronising checker.
// Optional build macro PRBS_ERR_INJECT_EN adds inj_err to flip bit 0 of the next generated word.
module prbs_gen_chk #(
    parameter int unsigned POL_W      = 7,
    parameter logic [31:0] POL_MASK   = 32'h0000_0060,
    parameter int unsigned DW         = 16,
    parameter int unsigned LOCK_CNT   = 4,
    parameter int unsigned UNLOCK_CNT = 4,
    parameter int unsigned ERR_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             gen_en,
    input  logic             gen_load,
    input  logic [POL_W-1:0] gen_seed,
    output logic             gen_valid,
    input  logic             gen_ready,
    output logic [DW-1:0]    gen_data,
    input  logic             chk_valid,
    input  logic [DW-1:0]    chk_data,
    input  logic             err_clr,
    output logic             locked,
    output logic [1:0]       chk_state,
    output logic             err_word,
    output logic [ERR_W-1:0] err_bits
`ifdef PRBS_ERR_INJECT_EN
    ,
    input  logic             inj_err
`endif
);

    localparam logic [POL_W-1:0] TAPS = POL_MASK[POL_W-1:0];
    localparam int unsigned PCW = $clog2(DW + 1);
    localparam int unsigned SW  = ((ERR_W > PCW) ? ERR_W : PCW) + 1;
    localparam int unsigned GW  = $clog2(LOCK_CNT + 1);
    localparam int unsigned BW  = $clog2(UNLOCK_CNT + 1);
    localparam logic [SW-1:0] ERR_MAX  = {{(SW-ERR_W){1'b0}}, {ERR_W{1'b1}}};
    localparam logic [GW-1:0] LOCK_N   = GW'(LOCK_CNT);
    localparam logic [BW-1:0] UNLOCK_N = BW'(UNLOCK_CNT);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } chk_st_e;

    // DW serial Fibonacci steps; first produced bit lands in the MSB.
    function automatic logic [DW-1:0] lfsr_word(input logic [POL_W-1:0] s_in);
        logic [POL_W-1:0] s;
        logic [DW-1:0]    w;
        logic             b;
        s = s_in;
        w = '0;
        for (int i = 0; i < int'(DW); i++) begin
            b = ^(s & TAPS);
            s = {s[POL_W-2:0], b};
            w[DW-1-i] = b;
        end
        return w;
    endfunction

    function automatic logic [PCW-1:0] popcnt(input logic [DW-1:0] v);
        logic [PCW-1:0] c;
        c = '0;
        for (int i = 0; i < int'(DW); i++) c = c + PCW'(v[i]);
        return c;
    endfunction

    function automatic logic [ERR_W-1:0] sat_add(input logic [ERR_W-1:0] a,
                                                 input logic [PCW-1:0]   b);
        logic [SW-1:0] sum;
        sum = SW'(a) + SW'(b);
        if (sum > ERR_MAX) return '1;
        return sum[ERR_W-1:0];
    endfunction

    // ---------------- generator ----------------
    logic [POL_W-1:0] gen_state_q, gen_state_d;
    logic [DW-1:0]    gen_data_q, gen_data_d;
    logic             gen_valid_q, gen_valid_d;
    logic [DW-1:0]    gen_word;
    logic [DW-1:0]    inj_mask;
    logic             gen_adv;

    assign gen_word = lfsr_word(gen_state_q);
    assign gen_adv  = gen_en && (!gen_valid_q || gen_ready) && !gen_load;

`ifdef PRBS_ERR_INJECT_EN
    logic inj_arm_q, inj_arm_d, inj_pend;
    assign inj_pend  = inj_arm_q | inj_err;
    assign inj_arm_d = inj_pend & ~gen_adv;
    assign inj_mask  = {{(DW-1){1'b0}}, inj_pend};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) inj_arm_q <= 1'b0;
        else        inj_arm_q <= inj_arm_d;
    end
`else
    assign inj_mask = '0;
`endif

    always_comb begin
        gen_state_d = gen_state_q;
        gen_data_d  = gen_data_q;
        gen_valid_d = gen_valid_q;
        if (gen_load) begin
            gen_state_d = (gen_seed == '0) ? '1 : gen_seed;
        end else if (gen_adv) begin
            // Next state is the tail of the word just produced.
            gen_state_d = gen_word[POL_W-1:0];
            gen_data_d  = gen_word ^ inj_mask;
            gen_valid_d = 1'b1;
        end else if (!gen_en && gen_ready) begin
            gen_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gen_state_q <= '1;
            gen_data_q  <= '0;
            gen_valid_q <= 1'b0;
        end else begin
            gen_state_q <= gen_state_d;
            gen_data_q  <= gen_data_d;
            gen_valid_q <= gen_valid_d;
        end
    end

    assign gen_valid = gen_valid_q;
    assign gen_data  = gen_data_q;

    // ---------------- checker ----------------
    chk_st_e          st_q;
    logic [POL_W-1:0] seed_q;
    logic [GW-1:0]    good_q;
    logic [BW-1:0]    bad_q;
    logic             locked_q;
    logic             err_word_q;
    logic [ERR_W-1:0] err_bits_q;

    logic [DW-1:0]    pred_word;
    logic [DW-1:0]    diff;
    logic [PCW-1:0]   pop;
    logic             match;
    logic [ERR_W-1:0] err_base;
    logic [GW-1:0]    good_inc;
    logic [BW-1:0]    bad_inc;

    assign pred_word = lfsr_word(seed_q);
    assign diff      = chk_data ^ pred_word;
    assign pop       = popcnt(diff);
    // All-zero input would seed the LFSR lockup state, so it never matches.
    assign match     = (diff == '0) && (chk_data != '0);
    assign err_base  = err_clr ? '0 : err_bits_q;
    assign good_inc  = good_q + GW'(1);
    assign bad_inc   = bad_q + BW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q       <= SEARCH;
            seed_q     <= '1;
            good_q     <= '0;
            bad_q      <= '0;
            locked_q   <= 1'b0;
            err_word_q <= 1'b0;
            err_bits_q <= '0;
        end else begin
            err_word_q <= 1'b0;
            if (err_clr) err_bits_q <= '0;
            if (chk_valid) begin
                case (st_q)
                    SEARCH: begin
                        seed_q <= chk_data[POL_W-1:0];
                        good_q <= '0;
                        st_q   <= VERIFY;
                    end
                    VERIFY: begin
                        seed_q <= chk_data[POL_W-1:0];
                        if (match) begin
                            good_q <= good_inc;
                            if (good_inc == LOCK_N) begin
                                st_q     <= LOCKED;
                                locked_q <= 1'b1;
                                bad_q    <= '0;
                            end
                        end else begin
                            st_q <= SEARCH;
                        end
                    end
                    LOCKED: begin
                        seed_q <= pred_word[POL_W-1:0];
                        if (pop != '0) begin
                            err_word_q <= 1'b1;
                            err_bits_q <= sat_add(err_base, pop);
                            if (bad_inc == UNLOCK_N) begin
                                st_q     <= SEARCH;
                                locked_q <= 1'b0;
                                bad_q    <= '0;
                            end else begin
                                bad_q <= bad_inc;
                            end
                        end else begin
                            bad_q <= '0;
                        end
                    end
                    default: begin
                        st_q     <= SEARCH;
                        locked_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign locked    = locked_q;
    assign chk_state = st_q;
    assign err_word  = err_word_q;
    assign err_bits  = err_bits_q;

endmodule

// File: tb/tb_prbs_gen_chk.sv
// Directed bench for prbs_gen_chk: PRBS7, DW=16, ERR_W=4 (to reach counter saturation).
module tb_prbs_gen_chk;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        gen_en = 1'b0;
    logic        gen_load = 1'b0;
    logic [6:0]  gen_seed = '0;
    logic        gen_valid;
    logic        gen_ready = 1'b0;
    logic [15:0] gen_data;
    logic        chk_valid = 1'b0;
    logic [15:0] chk_data = '0;
    logic        err_clr = 1'b0;
    logic        locked;
    logic [1:0]  chk_state;
    logic        err_word;
    logic [3:0]  err_bits;

    prbs_gen_chk #(
        .POL_W(7), .POL_MASK(32'h0000_0060), .DW(16),
        .LOCK_CNT(4), .UNLOCK_CNT(4), .ERR_W(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .gen_en(gen_en), .gen_load(gen_load), .gen_seed(gen_seed),
        .gen_valid(gen_valid), .gen_ready(gen_ready), .gen_data(gen_data),
        .chk_valid(chk_valid), .chk_data(chk_data), .err_clr(err_clr),
        .locked(locked), .chk_state(chk_state),
        .err_word(err_word), .err_bits(err_bits)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    logic [15:0] seq [0:127];

    typedef struct {
        logic       en;
        logic       rdy;
        logic       load;
        logic [6:0] seed;
        logic       exp_v;
        int         exp_idx;
    } gvec_t;
    gvec_t gv [15];

    // PRBS7 x^7+x^6+1 reference, bit-serial, MSB first.
    function automatic logic [15:0] mword(input logic [6:0] s_in);
        logic [6:0]  s;
        logic [15:0] w;
        logic        b;
        s = s_in;
        w = '0;
        for (int i = 0; i < 16; i++) begin
            b = s[6] ^ s[5];
            s = {s[5:0], b};
            w = {w[14:0], b};
        end
        return w;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_row(input int i, input logic en, input logic rdy, input logic load,
                           input logic [6:0] seed, input logic v, input int idx);
        gv[i].en = en; gv[i].rdy = rdy; gv[i].load = load;
        gv[i].seed = seed; gv[i].exp_v = v; gv[i].exp_idx = idx;
    endtask

    initial begin
        logic [6:0] s;
        int         exp_bits;
        int         sum;

        s = 7'h7F;
        for (int k = 0; k < 128; k++) begin
            seq[k] = mword(s);
            s = seq[k][6:0];
        end

        set_row(0,  1, 1, 0, 7'h00, 1, 0);
        set_row(1,  1, 1, 0, 7'h00, 1, 1);
        set_row(2,  1, 0, 0, 7'h00, 1, 1);
        set_row(3,  1, 0, 0, 7'h00, 1, 1);
        set_row(4,  1, 0, 0, 7'h00, 1, 1);
        set_row(5,  1, 0, 0, 7'h00, 1, 1);
        set_row(6,  1, 0, 0, 7'h00, 1, 1);
        set_row(7,  1, 1, 0, 7'h00, 1, 2);
        set_row(8,  0, 0, 0, 7'h00, 1, 2);
        set_row(9,  0, 1, 0, 7'h00, 0, 2);
        set_row(10, 1, 0, 0, 7'h00, 1, 3);
        set_row(11, 1, 1, 1, 7'h00, 1, 3);
        set_row(12, 1, 1, 0, 7'h00, 1, 0);
        set_row(13, 1, 1, 1, 7'h0C, 1, 0);
        set_row(14, 1, 1, 0, 7'h00, 1, 1);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_gen_valid", gen_valid, 0);
        check("rst_gen_data", gen_data, 0);
        check("rst_chk_state", chk_state, 0);
        check("rst_locked", locked, 0);
        check("rst_err_word", err_word, 0);
        check("rst_err_bits", err_bits, 0);
        rst_n = 1'b1;

        // Generator table: first word, backpressure, drain, load/seed
        for (int i = 0; i < 15; i++) begin
            gen_en = gv[i].en; gen_ready = gv[i].rdy;
            gen_load = gv[i].load; gen_seed = gv[i].seed;
            tick();
            check($sformatf("gen_valid[%0d]", i), gen_valid, gv[i].exp_v);
            check($sformatf("gen_data[%0d]", i), gen_data, seq[gv[i].exp_idx]);
            if (i == 0) check("first_word", gen_data, 16'h020C);
        end
        gen_load = 1'b0;

        // Full period: after 127 more words the sequence repeats
        gen_en = 1'b1; gen_ready = 1'b1;
        for (int k = 1; k <= 127; k++) begin
            tick();
            check($sformatf("period_w%0d", k), gen_data, seq[(1 + k) % 127]);
        end
        gen_en = 1'b0;
        tick();
        check("gen_drain_valid", gen_valid, 0);

        // Checker: zero word never verifies; skipped word drops back to SEARCH
        chk_valid = 1'b1; chk_data = 16'h0000; tick();
        check("zero_search", chk_state, 1);
        chk_data = 16'h0000; tick();
        check("zero_verify", chk_state, 0);
        chk_data = seq[10]; tick();
        check("mis_search", chk_state, 1);
        chk_data = seq[12]; tick();
        check("mis_verify", chk_state, 0);

        // Lock acquisition from phase 40, with an idle cycle in VERIFY
        for (int j = 0; j < 5; j++) begin
            if (j == 2) begin
                chk_valid = 1'b0; chk_data = 16'hFFFF; tick();
                check("idle_hold", chk_state, 1);
                chk_valid = 1'b1;
            end
            chk_data = seq[40 + j]; tick();
            check($sformatf("lock_state%0d", j), chk_state, (j < 4) ? 1 : 2);
            check($sformatf("lock_locked%0d", j), locked, (j == 4) ? 1 : 0);
        end
        check("lock_err_bits", err_bits, 0);
        check("lock_err_word", err_word, 0);

        // Three flipped bits while locked
        chk_data = seq[45] ^ 16'h0111; tick();
        check("err3_word", err_word, 1);
        check("err3_bits", err_bits, 3);
        check("err3_locked", locked, 1);
        chk_data = seq[46]; tick();
        check("good_after_word", err_word, 0);
        check("good_after_bits", err_bits, 3);
        check("good_after_locked", locked, 1);

        // err_clr coinciding with a 2-bit error
        chk_data = seq[47] ^ 16'h8001; err_clr = 1'b1; tick();
        err_clr = 1'b0;
        check("clr_err_bits", err_bits, 2);
        check("clr_err_word", err_word, 1);
        chk_data = seq[48]; tick();
        check("clr_next_word", err_word, 0);
        check("clr_next_state", chk_state, 2);

        // Four all-zero words: counter saturates, lock drops on the fourth
        exp_bits = 2;
        for (int j = 0; j < 4; j++) begin
            chk_data = 16'h0000; tick();
            sum = exp_bits + $countones(seq[49 + j]);
            exp_bits = (sum > 15) ? 15 : sum;
            check($sformatf("loss_bits%0d", j), err_bits, exp_bits);
            check($sformatf("loss_word%0d", j), err_word, 1);
            check($sformatf("loss_state%0d", j), chk_state, (j < 3) ? 2 : 0);
            check($sformatf("loss_locked%0d", j), locked, (j < 3) ? 1 : 0);
        end
        check("sat_at_15", err_bits, 15);

        chk_valid = 1'b0; err_clr = 1'b1; tick();
        err_clr = 1'b0;
        check("clr_alone", err_bits, 0);

        // Asynchronous reset mid-stream
        gen_en = 1'b1; gen_ready = 1'b1;
        chk_valid = 1'b1; chk_data = seq[5];
        tick();
        chk_valid = 1'b0;
        tick();
        check("pre_rst_valid", gen_valid, 1);
        check("pre_rst_state", chk_state, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_gen_valid", gen_valid, 0);
        check("arst_gen_data", gen_data, 0);
        check("arst_chk_state", chk_state, 0);
        check("arst_locked", locked, 0);
        check("arst_err_bits", err_bits, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        check("post_rst_valid", gen_valid, 1);
        check("post_rst_word", gen_data, 16'h020C);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/prbs_gen_chk.md
Name: prbs_gen_chk

Overview:
- Parametrised, registered successor to the team's combinational parallel PN-step logic.
- Contains a DW-bit-per-cycle Fibonacci LFSR pattern generator with a valid/ready output.
- Contains a self-synchronising pattern checker with a lock FSM, per-word error flag and saturating bit-error counter.
- Sits at the link BIST boundary: the generator drives the TX datapath and the checker monitors RX words.

Parameters:
- POL_W, 7, LFSR length in bits (2..31).
- POL_MASK, 32'h0000_0060, feedback tap mask over POL_W state bits; default is x^7+x^6+1 (PRBS7).
- DW, 16, bits produced or checked per word; must satisfy DW >= POL_W.
- LOCK_CNT, 4, consecutive error-free words in VERIFY required to lock (>=1).
- UNLOCK_CNT, 4, consecutive errored words in LOCKED required to drop lock (>=1).
- ERR_W, 16, width of the bit-error counter.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- gen_en  input  1  enable pattern generation
- gen_load  input  1  load gen_seed into the generator state
- gen_seed  input  POL_W  seed value; all-zero is replaced by all-ones
- gen_valid  output  1  gen_data holds a valid word
- gen_ready  input  1  downstream accepts gen_data
- gen_data  output  DW  generated word
- chk_valid  input  1  chk_data is valid this cycle
- chk_data  input  DW  received word
- err_clr  input  1  synchronously clear err_bits
- locked  output  1  checker is in LOCKED
- chk_state  output  2  FSM state: 0 SEARCH, 1 VERIFY, 2 LOCKED
- err_word  output  1  one-cycle pulse: the last checked word in LOCKED had at least one bit error
- err_bits  output  ERR_W  saturating count of bit errors in LOCKED

Behaviour:
- Serial step definition:
  - b = ^(s & POL_MASK[POL_W-1:0]); then s <= {s[POL_W-2:0], b}.
  - One word is DW serial steps. The first bit produced goes to data[DW-1] and the last to data[0].
- Generator reset values:
  - State is all-ones.
  - gen_valid = 0; gen_data = 0.
- Generator handshake and pipeline:
  - Output is a single register stage.
  - When gen_en && (!gen_valid || gen_ready), the next word is registered, the state advances DW steps, and gen_valid goes to 1.
  - When !gen_en && gen_ready, gen_valid goes to 0.
  - While gen_valid && !gen_ready, gen_data and gen_valid are held stable.
- gen_load:
  - Has priority over the advance.
  - The state takes gen_seed, or all-ones if gen_seed is zero.
  - gen_data and gen_valid are unchanged that cycle.
- Checker prediction: after DW >= POL_W steps, the LFSR state equals chk_data[POL_W-1:0], with s[0] = data[0]. The checker therefore predicts the next word from that state.
- Checker on chk_valid only; idle cycles change nothing:
  - SEARCH: reseed from chk_data[POL_W-1:0], clear the good-word counter, go to VERIFY.
  - VERIFY: compare chk_data to the prediction.
    - Match: increment the good counter and reseed; reaching LOCK_CNT goes to LOCKED.
    - Mismatch: reseed and go to SEARCH.
    - An all-zero received word always counts as a mismatch (avoids the LFSR lockup state).
  - LOCKED: free-run the predicted state; never reseed from data.
    - Compute the popcount of chk_data ^ predicted.
    - Nonzero: err_word pulses next cycle, err_bits += popcount (saturating at 2^ERR_W-1), and the bad counter increments.
    - Zero: the bad counter clears.
    - Bad counter reaching UNLOCK_CNT goes to SEARCH; errors on that word are still counted.
- err_clr:
  - Clears err_bits.
  - If it coincides with an errored word, the result is that word's popcount.
- Checker reset values:
  - chk_state = SEARCH; locked = 0; err_word = 0; err_bits = 0; both counters 0.
- Reset mid-operation: asynchronously returns every register to its reset value. Any in-flight gen_data word is discarded.

Optional Feature:
- Macro: PRBS_ERR_INJECT_EN.
- With the macro defined:
  - Adds input inj_err (1 bit).
  - A pulse on inj_err arms a flag.
  - The next word registered into gen_data has bit 0 inverted; the flag then clears.
  - The generator LFSR state itself is not corrupted.
- Without the macro: the port and flag are absent and generation is pure.

Test Plan:
- Generator first word: reset, defaults, gen_en=1, gen_ready=1 -> one cycle later gen_valid=1 and gen_data=16'h020C; the following words continue the PRBS7 sequence, and the period repeats after 127 words.
- Backpressure: gen_ready=0 for 5 cycles mid-stream -> gen_data and gen_valid held stable; no word lost or duplicated when gen_ready returns.
- Lock acquisition: feed the generator output into the checker from an arbitrary phase -> locked=1 after exactly 1+LOCK_CNT=5 valid words; err_bits=0.
- Error counting: while locked, flip 3 bits of one word -> err_word pulses once, err_bits=3, locked stays 1, and the next correct word is still predicted correctly.
- Lock loss: feed 4 consecutive all-zero words while locked -> chk_state returns to SEARCH after the 4th word; err_bits saturates correctly with ERR_W=4 at 15.
- Reset and seed: gen_seed=0 with gen_load -> state becomes all-ones; first word is 16'h020C. An async rst_n pulse mid-stream -> all outputs return to reset values immediately.
